// File: rtl/vga_rect_fill.sv
// Rectangle-fill pixel generator for the DESim VGA pixel interface: one pixel per clock,
// raster order inside the rectangle. Optional macro VGA_RECT_CLIP_EN suppresses plot off-screen.
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// DRAW  | busy=1, one pixel presented per cycle
// DONE  | done=1 for one cycle, then back to IDLE
module vga_rect_fill #(
    parameter int XMAX = 640,
    parameter int YMAX = 480
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x,
    input  logic [8:0] cmd_y,
    input  logic [9:0] cmd_w,
    input  logic [8:0] cmd_h,
    input  logic [2:0] cmd_color,
    output logic [9:0] VGA_X,
    output logic [8:0] VGA_Y,
    output logic [2:0] VGA_COLOR,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    if (XMAX < 1 || XMAX > 1024 || YMAX < 1 || YMAX > 512) begin : g_bad_bounds
        $error("vga_rect_fill: XMAX/YMAX outside the coordinate range");
    end

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [9:0] w_q, w_d;
    logic [8:0] h_q, h_d;
    logic [2:0] color_q, color_d;
    logic [9:0] i_q, i_d;
    logic [8:0] j_q, j_d;
    logic [9:0] vga_x_q, vga_x_d;
    logic [8:0] vga_y_q, vga_y_d;
    logic [2:0] vga_color_q, vga_color_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cmd_ready_q, cmd_ready_d;

    logic       accept;
    logic       last_col;
    logic       last_row;
    logic [9:0] i_step;
    logic [8:0] j_step;
    logic [9:0] pix_i;
    logic [8:0] pix_j;
    logic [9:0] base_x;
    logic [8:0] base_y;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       in_bounds;

    assign accept   = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign last_col = (i_q == w_q - 10'd1);
    assign last_row = (j_q == h_q - 9'd1);

    // Index of the pixel that the next edge will present.
    always_comb begin
        i_step = i_q + 10'd1;
        j_step = j_q;
        if (last_col) begin
            i_step = '0;
            j_step = j_q + 9'd1;
        end
    end

    assign pix_i  = accept ? 10'd0 : i_step;
    assign pix_j  = accept ? 9'd0  : j_step;
    assign base_x = accept ? cmd_x : x_q;
    assign base_y = accept ? cmd_y : y_q;

`ifdef VGA_RECT_CLIP_EN
    localparam logic [10:0] XMAX_W = 11'(XMAX);
    localparam logic [9:0]  YMAX_W = 10'(YMAX);

    logic [10:0] sum_x;
    logic [9:0]  sum_y;

    assign sum_x     = {1'b0, base_x} + {1'b0, pix_i};
    assign sum_y     = {1'b0, base_y} + {1'b0, pix_j};
    assign in_bounds = (sum_x < XMAX_W) && (sum_y < YMAX_W);
    assign pix_x     = sum_x[9:0];
    assign pix_y     = sum_y[8:0];
`else
    // Truncating adders give the modulo-1024 / modulo-512 wrap.
    assign pix_x     = base_x + pix_i;
    assign pix_y     = base_y + pix_j;
    assign in_bounds = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        i_d         = i_q;
        j_d         = j_q;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        plot_d      = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        cmd_ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    x_d         = cmd_x;
                    y_d         = cmd_y;
                    w_d         = cmd_w;
                    h_d         = cmd_h;
                    color_d     = cmd_color;
                    i_d         = '0;
                    j_d         = '0;
                    cmd_ready_d = 1'b0;
                    if (cmd_w == 10'd0 || cmd_h == 9'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_DRAW;
                        busy_d      = 1'b1;
                        plot_d      = in_bounds;
                        vga_x_d     = pix_x;
                        vga_y_d     = pix_y;
                        vga_color_d = cmd_color;
                    end
                end
            end

            ST_DRAW: begin
                if (last_col && last_row) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    i_d         = i_step;
                    j_d         = j_step;
                    busy_d      = 1'b1;
                    plot_d      = in_bounds;
                    vga_x_d     = pix_x;
                    vga_y_d     = pix_y;
                    vga_color_d = color_q;
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            i_q         <= '0;
            j_q         <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            i_q         <= i_d;
            j_q         <= j_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
            plot_q      <= plot_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign VGA_X     = vga_x_q;
    assign VGA_Y     = vga_y_q;
    assign VGA_COLOR = vga_color_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: directed and random rectangles checked cycle by cycle against
// a raster-loop model of the expected pixel stream.
module tb_vga_rect_fill;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_x;
    logic [8:0] cmd_y;
    logic [9:0] cmd_w;
    logic [8:0] cmd_h;
    logic [2:0] cmd_color;
    logic [9:0] VGA_X;
    logic [8:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic       plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    // Last pixel values the display interface should be holding.
    logic [9:0] lx = '0;
    logic [8:0] ly = '0;
    logic [2:0] lc = '0;

    vga_rect_fill dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x    (cmd_x),
        .cmd_y    (cmd_y),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_color(cmd_color),
        .VGA_X    (VGA_X),
        .VGA_Y    (VGA_Y),
        .VGA_COLOR(VGA_COLOR),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // Packed view: {plot, busy, done, cmd_ready, X, Y, COLOR}
    task automatic chk(input string tag, input logic [25:0] exp);
        logic [25:0] obs;
        obs = {plot, busy, done, cmd_ready, VGA_X, VGA_Y, VGA_COLOR};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs p=%b b=%b d=%b r=%b x=%0d y=%0d c=%0d exp p=%b b=%b d=%b r=%b x=%0d y=%0d c=%0d",
                   tag, obs[25], obs[24], obs[23], obs[22], obs[21:12], obs[11:3], obs[2:0],
                   exp[25], exp[24], exp[23], exp[22], exp[21:12], exp[11:3], exp[2:0]);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle_checks(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            chk(tag, {1'b0, 1'b0, 1'b0, 1'b1, lx, ly, lc});
            step();
        end
    endtask

    function automatic logic model_plot(input int xx, input int yy);
`ifdef VGA_RECT_CLIP_EN
        return (xx < 640) && (yy < 480);
`else
        return (xx >= 0) && (yy >= 0);
`endif
    endfunction

    // intrude: pixel index at which a second command is offered for two cycles (-1 = never)
    // rst_at:  pixel index after which reset is pulsed (-1 = never)
    task automatic run_cmd(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                           input logic [8:0] h, input logic [2:0] c,
                           input int intrude, input int rst_at);
        int n;
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        total++;
        assert (cmd_ready === 1'b1) else begin
            bad++;
            $error("FAIL ready_wait obs=%b exp=1", cmd_ready);
        end

        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_x = 10'($urandom); cmd_y = 9'($urandom);
        cmd_w = 10'($urandom); cmd_h = 9'($urandom); cmd_color = 3'($urandom);

        n = int'(w) * int'(h);
        for (int k = 0; k < n; k++) begin
            int xx;
            int yy;
            logic pl;
            xx = int'(x) + (k % int'(w));
            yy = int'(y) + (k / int'(w));
            pl = model_plot(xx, yy);
            lx = 10'(xx % 1024);
            ly = 9'(yy % 512);
            lc = c;
            chk("pixel", {pl, 1'b1, 1'b0, 1'b0, lx, ly, lc});
            if (k == rst_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                lx = '0; ly = '0; lc = '0;
                chk("mid_reset", {1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 9'd0, 3'd0});
                step();
                idle_checks("post_reset_idle", 20);
                return;
            end
            if (k == intrude) begin
                cmd_valid = 1'b1;
                cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = 3'd1;
            end
            if (k == intrude + 2) cmd_valid = 1'b0;
            step();
        end
        chk("done", {1'b0, 1'b0, 1'b1, 1'b0, lx, ly, lc});
        step();
        chk("ready_back", {1'b0, 1'b0, 1'b0, 1'b1, lx, ly, lc});
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_state", {1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 9'd0, 3'd0});
        idle_checks("idle_after_reset", 3);

        run_cmd(10'd5, 9'd7, 10'd3, 9'd2, 3'd4, -1, -1);
        run_cmd(10'd12, 9'd3, 10'd0, 9'd9, 3'd6, -1, -1);
        run_cmd(10'd20, 9'd30, 10'd5, 9'd0, 3'd2, -1, -1);
        run_cmd(10'd100, 9'd50, 10'd4, 9'd4, 3'd3, 4, -1);
        idle_checks("idle_after_ignored", 5);
        run_cmd(10'd200, 9'd60, 10'd4, 9'd4, 3'd5, -1, 2);
        run_cmd(10'd638, 9'd479, 10'd4, 9'd2, 3'd7, -1, -1);
        run_cmd(10'd1022, 9'd0, 10'd3, 9'd1, 3'd1, -1, -1);
        run_cmd(10'd1, 9'd510, 10'd1, 9'd4, 3'd2, -1, -1);

        for (int r = 0; r < 25; r++) begin
            run_cmd(10'($urandom), 9'($urandom), 10'($urandom_range(0, 6)),
                    9'($urandom_range(0, 5)), 3'($urandom), -1, -1);
            if (($urandom & 1) == 1) idle_checks("gap_idle", 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Rectangle-fill pixel generator that drives the DESim VGA pixel interface (`VGA_X`, `VGA_Y`, `VGA_COLOR`, `plot`) from inside `top`. It sits directly upstream of the simulated VGA display. It accepts one rectangle command at a time over a valid/ready handshake and emits exactly one pixel per clock, in raster order within the rectangle. It pulses `done` when the rectangle is complete.

## Interface
- `XMAX`, 640: display width; clipping bound on X.
- `YMAX`, 480: display height; clipping bound on Y.
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_x`  in  10  left column of the rectangle.
- `cmd_y`  in  9  top row of the rectangle.
- `cmd_w`  in  10  width in pixels; 0 is legal.
- `cmd_h`  in  9  height in pixels; 0 is legal.
- `cmd_color`  in  3  pixel colour, 0–7.
- `VGA_X`  out  10  current pixel column.
- `VGA_Y`  out  9  current pixel row.
- `VGA_COLOR`  out  3  current pixel colour.
- `plot`  out  1  pixel strobe; the display draws on each cycle `plot` is 1.
- `busy`  out  1  rectangle in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - DRAW: `busy`=1.
  - DONE: `done`=1 for exactly one cycle.
- IDLE transitions, on `cmd_valid`&&`cmd_ready`:
  - Latch x, y, w, h and colour.
  - Clear column counter `i` and row counter `j`.
  - If w==0 or h==0, go to DONE; otherwise go to DRAW.
- Each DRAW cycle:
  - Present pixel (x+i, y+j).
  - Then increment `i`. When `i`==w-1, reset `i` to 0 and increment `j`.
  - After the pixel with `i`==w-1 and `j`==h-1, go to DONE.
- DONE goes to IDLE unconditionally.
- `cmd_valid` while busy is ignored; it is not queued. Command inputs are sampled only on the accepting edge.
- Coordinate arithmetic:
  - X is computed as 11-bit x+i; Y as 10-bit y+j.
  - `VGA_X` and `VGA_Y` carry the low 10 and 9 bits respectively.
- Reset, including mid-rectangle: on the next edge the state is IDLE and all outputs are 0 except `cmd_ready`=1. The partial rectangle is abandoned with no `done` pulse.
- Outside DRAW: `plot`=0, and `VGA_X`/`VGA_Y`/`VGA_COLOR` hold their last values (0 after reset).

## Timing
- All outputs are registered.
- Accept edge is cycle 0. The first pixel, with `plot`=1, is visible after cycle 0 and on the following w·h−1 edges: one pixel per cycle, with no gap between rows.
- `done` is high the cycle after the last pixel cycle, and `cmd_ready` returns the cycle after that.
- Command-to-command spacing is a minimum of w·h+2 cycles.
- For a zero-size command: `done` is high the cycle after acceptance, with no `plot` pulses.
- `busy` equals (state==DRAW), registered together with `plot`.

## Configuration
- `VGA_RECT_CLIP_EN` defined:
  - Pixels with 11-bit X ≥ `XMAX` or 10-bit Y ≥ `YMAX` are still stepped, taking one cycle each, but `plot`=0 on that cycle.
  - The pixel count in cycles is unchanged.
- `VGA_RECT_CLIP_EN` undefined:
  - No bounds check; `plot`=1 on every DRAW cycle.
  - Coordinates wrap modulo 1024 (X) and 512 (Y) through truncation.

## Test plan
- Reset, then cmd (x=5, y=7, w=3, h=2, color=4) -> six `plot` cycles in the order (5,7)(6,7)(7,7)(5,8)(6,8)(7,8), all with colour 4. `done` follows one cycle after the last pixel; `cmd_ready` is high one cycle after `done`.
- cmd w=0, h=9 -> no `plot` pulses; `done` one cycle after acceptance; `busy` never high.
- Second `cmd_valid` (x=0, y=0, w=1, h=1) asserted during a 4×4 draw -> ignored: exactly 16 plots, one `done`, and then the block is idle.
- Reset asserted on the 3rd pixel of a 4×4 rectangle -> next edge: `plot`=0, `busy`=0, `done`=0, `VGA_X`=0, `VGA_Y`=0, `cmd_ready`=1. No further pixels are emitted.
- With `VGA_RECT_CLIP_EN`: cmd (x=638, y=479, w=4, h=2) -> 8 DRAW cycles with `plot`=1 only at (638,479) and (639,479); `done` after cycle 8.
- Without the macro: cmd (x=1022, y=0, w=3, h=1) -> plots at X=1022, 1023, 0.
